// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and DataM bus bundle for mem_access_unit
//
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  request handshake
//   rsp_valid/rsp_rdata/misalign                               completion
//   Dir/WriteData/MemWrite/ReadData                            word-only DataM port
// Modports: slave = the access unit, master = requester plus memory side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              misalign;
    logic [ADDR_W-1:0] Dir;
    logic [31:0]       WriteData;
    logic              MemWrite;
    logic [31:0]       ReadData;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
        output req_ready, rsp_valid, rsp_rdata, misalign, Dir, WriteData, MemWrite
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
        input  req_ready, rsp_valid, rsp_rdata, misalign, Dir, WriteData, MemWrite
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit in front of a word-only data memory
//
// Ports:
//   clock  rising-edge clock
//   Reset  synchronous active-low reset
//   bus    mem_access_unit_if.slave: request handshake, completion pulse with
//          load data and misalign flag, and the DataM Dir/WriteData/MemWrite/ReadData port
// One request in flight. Sub-word stores become a read-modify-write of the
// containing word; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              Reset,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WR, RESP} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [31:0]       merge_q;
    logic [31:0]       rsp_rdata_q;
    logic              misalign_q;

    function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 1'b0;
            3'b100:  return we;             // unsigned variants have no store form
            3'b001:  return a[0];
            3'b101:  return we | a[0];
            3'b010:  return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [31:0] s;
        logic [15:0] h;
        s = w >> {a, 3'b000};
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] rd, input logic [31:0] wd);
        logic [31:0] m;
        m = rd;
        if (f3 == 3'b000) begin
            case (a)
                2'd0: m[7:0]   = wd[7:0];
                2'd1: m[15:8]  = wd[7:0];
                2'd2: m[23:16] = wd[7:0];
                2'd3: m[31:24] = wd[7:0];
            endcase
        end else if (a[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        return m;
    endfunction

    always_ff @(posedge clock) begin
        if (!Reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            merge_q     <= '0;
            rsp_rdata_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        funct3_q    <= bus.req_funct3;
                        misalign_q  <= is_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
                        rsp_rdata_q <= '0;
                    end
                end
                LOAD:   rsp_rdata_q <= extract(funct3_q, addr_q[1:0], bus.ReadData);
                RMW_RD: merge_q     <= merge(funct3_q, addr_q[1:0], bus.ReadData, wdata_q);
                RESP: begin
                    rsp_rdata_q <= '0;
                    misalign_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n       = state;
        bus.req_ready = (state == IDLE) & Reset;
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.misalign  = misalign_q;
        bus.Dir       = '0;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (is_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0]))
                        state_n = RESP;
                    else if (!bus.req_we)
                        state_n = LOAD;
                    else if (bus.req_funct3 == 3'b010)
                        state_n = WR;
                    else
                        state_n = RMW_RD;
                end
            end
            LOAD, RMW_RD: begin
                bus.Dir = {addr_q[ADDR_W-1:2], 2'b00};
                state_n = (state == LOAD) ? RESP : WR;
            end
            WR: begin
                bus.Dir       = {addr_q[ADDR_W-1:2], 2'b00};
                bus.MemWrite  = Reset;      // a reset edge must never commit a write
                bus.WriteData = (funct3_q == 3'b010) ? wdata_q : merge_q;
                state_n       = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    logic clock = 1'b0;
    logic Reset = 1'b0;
    always #5 clock = ~clock;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [31:0] mem [16];
    int          wr_count = 0;
    logic [31:0] last_dir = '0;
    logic [31:0] last_wdata = '0;
    int          checks = 0;
    int          errors = 0;

    assign bus.ReadData = mem[bus.Dir[5:2]];

    always @(posedge clock) begin
        if (bus.MemWrite) begin
            mem[bus.Dir[5:2]] <= bus.WriteData;
            wr_count   = wr_count + 1;
            last_dir   = bus.Dir;
            last_wdata = bus.WriteData;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                          output int lat, output int nwr);
        int  w0;
        bit  seen;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        w0 = wr_count;
        @(negedge clock);
        bus.req_valid = 1'b0;
        seen = 0;
        rd = '0;
        mis = 1'b0;
        lat = 1;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.rsp_valid) begin
                seen = 1;
                rd   = bus.rsp_rdata;
                mis  = bus.misalign;
            end else begin
                lat++;
                @(negedge clock);
            end
        end
        if (!seen) check("rsp_timeout", 32'd0, 32'd1);
        nwr = wr_count - w0;
        @(negedge clock);
        check("rsp_single_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis,
                        input int exp_lat, input int exp_nwr);
        logic [31:0] rd;
        logic        mis;
        int          lat, nwr;
        do_req(we, f3, addr, wd, rd, mis, lat, nwr);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_misalign"}, {31'd0, mis}, {31'd0, exp_mis});
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_writes"}, nwr, exp_nwr);
    endtask

    initial begin
        int w0;
        int rsp_seen;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        // T1: reset held for two edges
        @(posedge clock);
        @(negedge clock);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        check("rst_dir", bus.Dir, 32'd0);
        check("rst_wdata", bus.WriteData, 32'd0);
        check("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("rst_ready2", {31'd0, bus.req_ready}, 32'd0);
        Reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        // T2: word store then word load
        xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        check("sw10_dir", last_dir, 32'h10);
        xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        // T3: byte store into lane 3 via read-modify-write
        xact("sw14", 1'b1, 3'b010, 32'h14, 32'h11223344, 32'h0, 1'b0, 2, 1);
        xact("sb17", 1'b1, 3'b000, 32'h17, 32'h000000A5, 32'h0, 1'b0, 3, 1);
        check("sb17_dir", last_dir, 32'h14);
        check("sb17_word", last_wdata, 32'hA5223344);
        xact("lb17", 1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 0);
        xact("lbu17", 1'b0, 3'b100, 32'h17, 32'h0, 32'h000000A5, 1'b0, 2, 0);

        // T4: halfword store into upper half
        xact("sh16", 1'b1, 3'b001, 32'h16, 32'h00008001, 32'h0, 1'b0, 3, 1);
        check("sh16_word", last_wdata, 32'h80013344);
        xact("lh16", 1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 1'b0, 2, 0);
        xact("lhu16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h00008001, 1'b0, 2, 0);
        xact("lh14", 1'b0, 3'b001, 32'h14, 32'h0, 32'h00003344, 1'b0, 2, 0);
        xact("lb15", 1'b0, 3'b000, 32'h15, 32'h0, 32'h00000033, 1'b0, 2, 0);

        // T5: faults complete in one cycle and never touch memory
        xact("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("sh13", 1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0, 1'b1, 1, 0);
        xact("sbu14", 1'b1, 3'b100, 32'h14, 32'h000000FF, 32'h0, 1'b1, 1, 0);
        xact("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("lw14_a", 1'b0, 3'b010, 32'h14, 32'h0, 32'h80013344, 1'b0, 2, 0);

        // T6: reset during RMW_RD of SB 0x14
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h14;
        bus.req_wdata  = 32'h000000EE;
        w0 = wr_count;
        rsp_seen = 0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("t6_in_rmw_dir", bus.Dir, 32'h14);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (bus.rsp_valid) rsp_seen++;
        end
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (bus.rsp_valid) rsp_seen++;
        end
        check("t6_no_write", wr_count - w0, 32'd0);
        check("t6_no_rsp", rsp_seen, 32'd0);
        check("t6_mem", mem[5], 32'h80013344);
        xact("lw14_b", 1'b0, 3'b010, 32'h14, 32'h0, 32'h80013344, 1'b0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
